// File: rtl/adder_wrapper_bist.sv
// BIST driver/checker for a registered adder wrapper: LFSR operands out,
// wrapper sum/cout in, compared against a pipelined golden a+b.
module adder_wrapper_bist #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [31:0] SEED        = 32'hACE1_1234
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] res_sum,
   input  logic             res_cout,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [15:0]      first_err_idx
);

   localparam logic [31:0] SEED_EFF = (SEED == '0) ? 32'd1 : SEED;
   localparam logic [31:0] MASK     = 32'h8020_0003;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [31:0]       lfsr_q, lfsr_d;
   logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
   logic [15:0]       issue_q, issue_d;
   logic [15:0]       err_q, err_d, first_q, first_d;
   logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;

   // Stage 0 loads together with op_a/op_b; stage k holds the vector that was
   // on the op registers k cycles earlier, so stage LATENCY lines up with res_*.
   logic [LATENCY:0]  vld_q, vld_d;
   logic [WIDTH:0]    exp_q [LATENCY+1];
   logic [WIDTH:0]    exp_d [LATENCY+1];
   logic [15:0]       idx_q [LATENCY+1];
   logic [15:0]       idx_d [LATENCY+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED_EFF;
         op_a_q  <= '0;
         op_b_q  <= '0;
         issue_q <= '0;
         err_q   <= '0;
         first_q <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         vld_q   <= '0;
         for (int unsigned k = 0; k <= LATENCY; k++) begin
            exp_q[k] <= '0;
            idx_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         issue_q <= issue_d;
         err_q   <= err_d;
         first_q <= first_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         vld_q   <= vld_d;
         for (int unsigned k = 0; k <= LATENCY; k++) begin
            exp_q[k] <= exp_d[k];
            idx_q[k] <= idx_d[k];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_RUN;
         S_RUN:          if (issue_q == 16'(NUM_VECTORS - 1)) state_d = S_DRAIN;
         S_DRAIN:        if (vld_q[LATENCY-1:0] == '0) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      lfsr_d  = lfsr_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      issue_d = issue_q;
      err_d   = err_q;
      first_d = first_q;
      vld_d   = {vld_q[LATENCY-1:0], 1'b0};
      exp_d[0] = '0;
      idx_d[0] = '0;
      for (int unsigned k = 1; k <= LATENCY; k++) begin
         exp_d[k] = exp_q[k-1];
         idx_d[k] = idx_q[k-1];
      end

      if (vld_q[LATENCY] && ({res_cout, res_sum} != exp_q[LATENCY])) begin
         if (err_q != '1) err_d = err_q + 16'd1;
         if (first_q == '1) first_d = idx_q[LATENCY];
      end

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               lfsr_d  = SEED_EFF;
               issue_d = '0;
               err_d   = '0;
               first_d = '1;
            end
         end
         S_RUN: begin
            op_a_d   = lfsr_q[WIDTH-1:0];
            op_b_d   = lfsr_q[31:32-WIDTH];
            lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : 32'd0);
            vld_d[0] = 1'b1;
            exp_d[0] = {1'b0, lfsr_q[WIDTH-1:0]} + {1'b0, lfsr_q[31:32-WIDTH]};
            idx_d[0] = issue_q;
            issue_d  = issue_q + 16'd1;
         end
         default: ;
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
      pass_d = (state_d == S_DONE) && (err_d == '0);
   end

   assign op_a          = op_a_q;
   assign op_b          = op_b_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = first_q;

endmodule

// File: tb/tb_adder_wrapper_bist.sv
// Bench for adder_wrapper_bist: a behavioural wrapper with selectable latency
// and faults, plus a bench LFSR model that supplies every expected value.
module tb_adder_wrapper_bist;

   localparam int unsigned W = 16;
   localparam int unsigned N = 256;
   localparam logic [31:0] SEED = 32'hACE1_1234;
   localparam logic [31:0] MASK = 32'h8020_0003;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start3 = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] op_a, op_b, res_sum;
   logic         res_cout, busy, done, pass;
   logic [15:0]  err_count, first_err_idx;

   logic [W-1:0] op_a3, op_b3, res_sum3;
   logic         res_cout3, busy3, done3, pass3;
   logic [15:0]  err_count3, first_err_idx3;

   adder_wrapper_bist #(.WIDTH(W), .LATENCY(2), .NUM_VECTORS(N), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
      .res_sum(res_sum), .res_cout(res_cout), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_idx(first_err_idx));

   adder_wrapper_bist #(.WIDTH(W), .LATENCY(3), .NUM_VECTORS(N), .SEED(SEED)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .op_a(op_a3), .op_b(op_b3),
      .res_sum(res_sum3), .res_cout(res_cout3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err_count3), .first_err_idx(first_err_idx3));

   // Wrapper model: wlat register stages; fmode 1 = sum[0] stuck 0, 2 = cout flip on vector 5.
   int           wlat = 2;
   int           fmode = 0;
   logic [W-1:0] v5_a = '0, v5_b = '0;
   logic [W:0]   wp  [3];
   logic [W:0]   wp3 [3];

   function automatic logic [W:0] wsum(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input int mode, input logic [W-1:0] fa, input logic [W-1:0] fb);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (mode == 1) s[0] = 1'b0;
      if (mode == 2 && a == fa && b == fb) s[W] = ~s[W];
      return s;
   endfunction

   always @(posedge clk) begin
      wp[0]  <= wsum(op_a, op_b, fmode, v5_a, v5_b);
      wp[1]  <= wp[0];
      wp[2]  <= wp[1];
      wp3[0] <= wsum(op_a3, op_b3, 0, '0, '0);
      wp3[1] <= wp3[0];
      wp3[2] <= wp3[1];
   end

   always_comb begin
      {res_cout, res_sum} = (wlat == 3) ? wp[2] : wp[1];
      {res_cout3, res_sum3} = wp3[2];
   end

   function automatic logic [31:0] lnext(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? MASK : 32'd0);
   endfunction

   int passed = 0;
   int total  = 0;
   logic [W-1:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];
   int busy_cnt, done_edge;

   task automatic push_expected();
      logic [31:0] l;
      exp_a.delete();
      exp_b.delete();
      l = SEED;
      for (int i = 0; i < int'(N); i++) begin
         exp_a.push_back(l[W-1:0]);
         exp_b.push_back(l[31:32-W]);
         l = lnext(l);
      end
   endtask

   // Drives one run on dut; records busy cycles, done edge and issued operands.
   task automatic run_dut(input int pulse1, input int pulse2, input int abort_at);
      obs_a.delete();
      obs_b.delete();
      busy_cnt  = 0;
      done_edge = -1;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (k == abort_at) begin
            rst_n = 1'b0;
            break;
         end
         if (busy) busy_cnt++;
         if (k >= 1 && k <= int'(N)) begin
            obs_a.push_back(op_a);
            obs_b.push_back(op_b);
         end
         start = (k == pulse1 || k == pulse2);
         if (done) begin
            done_edge = k;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({op_a, op_b, busy, done, pass, err_count, first_err_idx} !== {16'h0, 16'h0, 3'b000, 16'h0, 16'hFFFF}) begin
         $display("FAIL reset_values got op_a=%h op_b=%h busy=%b done=%b pass=%b err=%h first=%h",
                  op_a, op_b, busy, done, pass, err_count, first_err_idx);
      end else passed++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_loopback();
      fmode = 0;
      wlat  = 2;
      push_expected();
      run_dut(-1, -1, -1);
      total++;
      if (busy_cnt !== int'(N) + 3) $display("FAIL loop_busy got %0d want %0d", busy_cnt, N + 3);
      else passed++;
      total++;
      if (done_edge !== int'(N) + 3) $display("FAIL loop_done_edge got %0d want %0d", done_edge, N + 3);
      else passed++;
      total++;
      if ({pass, err_count, first_err_idx} !== {1'b1, 16'h0, 16'hFFFF})
         $display("FAIL loop_result got pass=%b err=%0d first=%h want 1/0/ffff", pass, err_count, first_err_idx);
      else passed++;
      total++;
      if (obs_a.size() !== int'(N)) $display("FAIL loop_vec_count got %0d want %0d", obs_a.size(), N);
      else passed++;
      for (int i = 0; i < int'(N) && obs_a.size() > 0; i++) begin
         logic [W-1:0] ea, eb, oa, ob;
         ea = exp_a.pop_front();
         eb = exp_b.pop_front();
         oa = obs_a.pop_front();
         ob = obs_b.pop_front();
         total++;
         if (oa !== ea || ob !== eb) $display("FAIL loop_ops[%0d] got %h/%h want %h/%h", i, oa, ob, ea, eb);
         else passed++;
      end
   endtask

   task automatic test_stuck_sum0();
      logic [31:0] l;
      int ecnt, efirst;
      l = SEED;
      ecnt = 0;
      efirst = 16'hFFFF;
      for (int i = 0; i < int'(N); i++) begin
         if (l[0] ^ l[32-W]) begin
            if (ecnt == 0) efirst = i;
            ecnt++;
         end
         l = lnext(l);
      end
      fmode = 1;
      run_dut(-1, -1, -1);
      total++;
      if (done !== 1'b1 || pass !== 1'b0) $display("FAIL stuck_pass got done=%b pass=%b want 1/0", done, pass);
      else passed++;
      total++;
      if (int'(err_count) !== ecnt) $display("FAIL stuck_err got %0d want %0d", err_count, ecnt);
      else passed++;
      total++;
      if (int'(first_err_idx) !== efirst) $display("FAIL stuck_first got %0d want %0d", first_err_idx, efirst);
      else passed++;
      fmode = 0;
   endtask

   task automatic test_cout_flip();
      logic [31:0] l;
      l = SEED;
      for (int i = 0; i < 5; i++) l = lnext(l);
      v5_a  = l[W-1:0];
      v5_b  = l[31:32-W];
      fmode = 2;
      run_dut(-1, -1, -1);
      total++;
      if ({pass, err_count, first_err_idx} !== {1'b0, 16'd1, 16'd5})
         $display("FAIL cout_flip got pass=%b err=%0d first=%0d want 0/1/5", pass, err_count, first_err_idx);
      else passed++;
      fmode = 0;
   endtask

   task automatic test_latency_mismatch();
      int k;
      wlat = 3;
      run_dut(-1, -1, -1);
      total++;
      if (!(int'(err_count) > 200) || pass !== 1'b0 || done !== 1'b1)
         $display("FAIL lat_mismatch got err=%0d pass=%b done=%b want >200/0/1", err_count, pass, done);
      else passed++;
      wlat = 2;
      @(negedge clk) start3 = 1'b1;
      @(posedge clk);
      #1 start3 = 1'b0;
      k = 0;
      while (!done3 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      total++;
      if (done3 !== 1'b1 || pass3 !== 1'b1 || err_count3 !== 16'h0)
         $display("FAIL lat3_match got done=%b pass=%b err=%0d want 1/1/0", done3, pass3, err_count3);
      else passed++;
   endtask

   task automatic test_start_ignored();
      run_dut(10, 100, -1);
      total++;
      if (busy_cnt !== int'(N) + 3) $display("FAIL ign_busy got %0d want %0d", busy_cnt, N + 3);
      else passed++;
      total++;
      if (done_edge !== int'(N) + 3 || pass !== 1'b1)
         $display("FAIL ign_done got edge=%0d pass=%b want %0d/1", done_edge, pass, N + 3);
      else passed++;
   endtask

   task automatic test_restart();
      logic [W-1:0] ea, eb, oa, ob;
      int bad;
      push_expected();
      run_dut(-1, -1, -1);
      total++;
      if (obs_a.size() == 0 || obs_a[0] !== SEED[W-1:0])
         $display("FAIL restart_first_op got %h want %h", (obs_a.size() > 0) ? obs_a[0] : 16'hxxxx, SEED[W-1:0]);
      else passed++;
      bad = 0;
      while (obs_a.size() > 0 && exp_a.size() > 0) begin
         ea = exp_a.pop_front();
         eb = exp_b.pop_front();
         oa = obs_a.pop_front();
         ob = obs_b.pop_front();
         if (oa !== ea || ob !== eb) bad++;
      end
      total++;
      if (bad !== 0 || exp_a.size() !== 0) $display("FAIL restart_seq got %0d bad, %0d missing want 0/0", bad, exp_a.size());
      else passed++;
      total++;
      if (pass !== 1'b1) $display("FAIL restart_pass got %b want 1", pass);
      else passed++;
   endtask

   task automatic test_reset_abort();
      run_dut(-1, -1, 50);
      #1;
      total++;
      if ({op_a, op_b, busy, done, pass, err_count, first_err_idx} !== {16'h0, 16'h0, 3'b000, 16'h0, 16'hFFFF})
         $display("FAIL abort_values got op_a=%h op_b=%h busy=%b done=%b pass=%b err=%h first=%h",
                  op_a, op_b, busy, done, pass, err_count, first_err_idx);
      else passed++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_idle got done=%b busy=%b want 0/0", done, busy);
      else passed++;
      run_dut(-1, -1, -1);
      total++;
      if (done_edge !== int'(N) + 3 || pass !== 1'b1 || err_count !== 16'h0)
         $display("FAIL abort_rerun got edge=%0d pass=%b err=%0d want %0d/1/0", done_edge, pass, err_count, N + 3);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_stuck_sum0();
      test_cout_flip();
      test_latency_mismatch();
      test_start_ignored();
      test_restart();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
